psx_trace_player: RTL and testbench

- Synthesizable, parametrised successor to the bench-only PSX capture replayer.
- Stores a delta-timestamped trace of CH_W logic channels in internal RAM and replays it cycle-accurately onto output pins.
- Supports one-shot or looped playback, programmable trace length, abort, and a tick prescaler.
- Sits in t_rex/controller/psx. It drives clk/cmd/att (default CH_W=3) into the PSX receiver, or into the DUT in hardware-in-loop benches.

---
 rtl/psx_trace_pkg.sv | 21 ++
 rtl/psx_trace_ram.sv | 28 ++
 rtl/psx_trace_player.sv | 200 ++++++++++++++++++++
 tb/tb_psx_trace_player.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_trace_pkg.sv
// Shared types for the PSX trace player: FSM states and the stored trace entry.
// Default channel/delta widths live here so the player and its users agree on them.
package psx_trace_pkg;

  localparam int PSX_CH_W   = 3;
  localparam int PSX_TIME_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    LOAD,
    WAIT,
    DONE
  } state_e;

  typedef struct packed {
    logic [PSX_TIME_W-1:0] delta;
    logic [PSX_CH_W-1:0]   val;
  } psx_entry_t;

endpackage

// File: rtl/psx_trace_ram.sv
// Simple dual-port trace store: one write port, one synchronous read port
// whose output holds while rd_en is low.
module psx_trace_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array and its read register have no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/psx_trace_player.sv
// Cycle-accurate replayer of a delta-timestamped channel trace held in internal RAM.
// The next entry is always prefetched while waiting, so back-to-back applies have no gap.
module psx_trace_player
  import psx_trace_pkg::*;
#(
  parameter int              CH_W     = PSX_CH_W,
  parameter int              TIME_W   = PSX_TIME_W,
  parameter int              DEPTH    = 512,
  parameter int              TICK_DIV = 1,
  parameter logic [CH_W-1:0] IDLE_VAL = {CH_W{1'b1}},
  localparam int             ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TIME_W-1:0] wr_delta,
  input  logic [CH_W-1:0]   wr_val,
  input  logic [ADDR_W:0]   len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  output logic [CH_W-1:0]   ch_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_idx,
  output logic [7:0]        loop_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     PSC_RELOAD = 16'(TICK_DIV - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_out_q, ch_out_d, cur_val_q, cur_val_d;
  logic                busy_q, busy_d, done_q, done_d, loop_q, loop_d;
  logic [ADDR_W-1:0]   cur_idx_q, cur_idx_d, cur_i_q, cur_i_d, nxt_i_q, nxt_i_d;
  logic [7:0]          loop_cnt_q, loop_cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [15:0]         psc_q, psc_d;
  logic [TIME_W-1:0]   cnt_q, cnt_d;

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr, last_idx, nxt_wrap;
  logic [TIME_W+CH_W-1:0] rd_data;
  logic [TIME_W-1:0]   rd_delta, rd_ticks;
  logic [CH_W-1:0]     rd_val;
  logic                len_ok, start_acc, tick;

  assign rd_delta  = rd_data[CH_W +: TIME_W];
  assign rd_val    = rd_data[CH_W-1:0];
  assign rd_ticks  = (rd_delta == '0) ? TIME_W'(1) : rd_delta;
  assign len_ok    = (len != '0) && (len <= DEPTH_L);
  assign start_acc = (state_q == IDLE) && start && !abort && len_ok;
  assign tick      = (psc_q == '0);
  assign last_idx  = ADDR_W'(len_q - 1'b1);
  assign nxt_wrap  = (nxt_i_q == last_idx) ? '0 : nxt_i_q + 1'b1;

  psx_trace_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(TIME_W + CH_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en && !busy_q && !start_acc),
    .wr_addr(wr_addr),
    .wr_data({wr_delta, wr_val}),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    ch_out_d   = ch_out_q;
    cur_val_d  = cur_val_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    loop_d     = loop_q;
    cur_idx_d  = cur_idx_q;
    cur_i_d    = cur_i_q;
    nxt_i_d    = nxt_i_q;
    loop_cnt_d = loop_cnt_q;
    len_d      = len_q;
    psc_d      = psc_q;
    cnt_d      = cnt_q;
    rd_en      = 1'b0;
    rd_addr    = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            state_d  = FETCH0;
            busy_d   = 1'b1;
            len_d    = len;
            loop_d   = loop_en;
            psc_d    = PSC_RELOAD;
            ch_out_d = IDLE_VAL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH0: begin
        rd_en   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        cur_val_d = rd_val;
        cnt_d     = rd_ticks;
        cur_i_d   = '0;
        nxt_i_d   = (last_idx == '0) ? '0 : ADDR_W'(1);
        rd_en     = 1'b1;
        rd_addr   = nxt_i_d;
        state_d   = WAIT;
      end
      WAIT: begin
        if (!tick) begin
          psc_d = psc_q - 1'b1;
        end else begin
          psc_d = PSC_RELOAD;
          if (cnt_q != TIME_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // Apply the held entry and promote the prefetched one in the same cycle.
            ch_out_d  = cur_val_q;
            cur_idx_d = cur_i_q;
            cur_val_d = rd_val;
            cnt_d     = rd_ticks;
            cur_i_d   = nxt_i_q;
            nxt_i_d   = nxt_wrap;
            rd_en     = 1'b1;
            rd_addr   = nxt_wrap;
            if (cur_i_q == last_idx) begin
              if (loop_q) begin
                loop_cnt_d = (loop_cnt_q == 8'hFF) ? loop_cnt_q : loop_cnt_q + 8'd1;
              end else begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && busy_q) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      ch_out_d   = IDLE_VAL;
      cur_idx_d  = cur_idx_q;
      loop_cnt_d = loop_cnt_q;
      rd_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_out_q   <= IDLE_VAL;
      cur_val_q  <= IDLE_VAL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loop_q     <= 1'b0;
      cur_idx_q  <= '0;
      cur_i_q    <= '0;
      nxt_i_q    <= '0;
      loop_cnt_q <= '0;
      len_q      <= '0;
      psc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_out_q   <= ch_out_d;
      cur_val_q  <= cur_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loop_q     <= loop_d;
      cur_idx_q  <= cur_idx_d;
      cur_i_q    <= cur_i_d;
      nxt_i_q    <= nxt_i_d;
      loop_cnt_q <= loop_cnt_d;
      len_q      <= len_d;
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ch_out   = ch_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_idx  = cur_idx_q;
  assign loop_cnt = loop_cnt_q;

endmodule

// File: tb/tb_psx_trace_player.sv
// Two players (TICK_DIV=1 and 4) share one stimulus stream; each is compared every
// cycle against an apply-schedule model built from start cycle + prefix sums of deltas.
module tb_psx_trace_player;
  import psx_trace_pkg::*;

  localparam logic [2:0] IDLE_V = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, start = 1'b0, abort = 1'b0, loop_en = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [15:0] wr_delta = '0;
  logic [2:0] wr_val = '0;
  logic [9:0] len = '0;

  logic [2:0] o_ch [2];
  logic       o_busy [2], o_done [2];
  logic [8:0] o_idx [2];
  logic [7:0] o_lc [2];

  int n_cmp = 0, n_bad = 0, cyc = 0, s0 = 0;

  // Model state, one slot per player.
  psx_entry_t m_mem [2][512];
  int         m_busy [2], m_in_done [2], m_c0 [2], m_len [2], m_loop [2];
  int         m_next_k [2], m_next_i [2];
  logic [2:0] e_ch [2];
  logic       e_busy [2], e_done [2];
  logic [8:0] e_idx [2];
  int         e_lc [2];

  always #5 clk = ~clk;

  psx_trace_player #(.TICK_DIV(1)) u_dut_t1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_delta(wr_delta),
    .wr_val(wr_val), .len(len), .loop_en(loop_en), .start(start), .abort(abort),
    .ch_out(o_ch[0]), .busy(o_busy[0]), .done(o_done[0]), .cur_idx(o_idx[0]),
    .loop_cnt(o_lc[0]));

  psx_trace_player #(.TICK_DIV(4)) u_dut_t4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_delta(wr_delta),
    .wr_val(wr_val), .len(len), .loop_en(loop_en), .start(start), .abort(abort),
    .ch_out(o_ch[1]), .busy(o_busy[1]), .done(o_done[1]), .cur_idx(o_idx[1]),
    .loop_cnt(o_lc[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int td_of(int j);
    return (j == 0) ? 1 : 4;
  endfunction

  function automatic int ticks_of(int j, int i);
    return (m_mem[j][i].delta == 16'd0) ? 1 : int'(m_mem[j][i].delta);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 0; m_in_done[j] = 0;
      e_ch[j] = IDLE_V; e_busy[j] = 1'b0; e_done[j] = 1'b0; e_idx[j] = '0; e_lc[j] = 0;
    end
  endtask

  // Predict outputs visible in cycle cyc+1 from the inputs applied in cycle cyc.
  task automatic model_step(int j);
    int busy_now, acc, done_n, in_done_n, t;
    busy_now = m_busy[j]; acc = 0; done_n = 0; in_done_n = 0;
    t = cyc - m_c0[j];
    if (m_busy[j] != 0) begin
      if (abort) begin
        m_busy[j] = 0;
        e_ch[j] = IDLE_V;
      end else if (t == m_next_k[j]) begin
        e_ch[j]  = m_mem[j][m_next_i[j]].val;
        e_idx[j] = 9'(m_next_i[j]);
        if (m_next_i[j] == m_len[j] - 1) begin
          if (m_loop[j] != 0) e_lc[j] = (e_lc[j] < 255) ? e_lc[j] + 1 : 255;
          else begin m_busy[j] = 0; done_n = 1; in_done_n = 1; end
          m_next_i[j] = 0;
        end else begin
          m_next_i[j]++;
        end
        m_next_k[j] += td_of(j) * ticks_of(j, m_next_i[j]);
      end
    end else if (m_in_done[j] == 0 && start && !abort) begin
      if (len >= 10'd1 && len <= 10'd512) begin
        acc = 1; m_busy[j] = 1; m_c0[j] = cyc; e_ch[j] = IDLE_V;
        m_len[j] = int'(len); m_loop[j] = int'(loop_en);
        m_next_i[j] = 0; m_next_k[j] = 2 + td_of(j) * ticks_of(j, 0);
      end else begin
        done_n = 1;
      end
    end
    if (wr_en && busy_now == 0 && acc == 0) m_mem[j][wr_addr] = '{delta: wr_delta, val: wr_val};
    e_busy[j] = (m_busy[j] != 0);
    e_done[j] = (done_n != 0);
    m_in_done[j] = in_done_n;
  endtask

  task automatic step();
    for (int j = 0; j < 2; j++) model_step(j);
    @(negedge clk);
    cyc++;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("t%0d_ch", j),   o_ch[j],   e_ch[j]);
      check($sformatf("t%0d_busy", j), o_busy[j], e_busy[j]);
      check($sformatf("t%0d_done", j), o_done[j], e_done[j]);
      check($sformatf("t%0d_idx", j),  o_idx[j],  e_idx[j]);
      check($sformatf("t%0d_lc", j),   o_lc[j],   e_lc[j]);
    end
    start = 1'b0; abort = 1'b0; wr_en = 1'b0;
  endtask

  task automatic goto(int r);
    while (cyc < s0 + r) step();
  endtask

  task automatic write_entry(int a, int d, logic [2:0] v);
    wr_en = 1'b1; wr_addr = 9'(a); wr_delta = 16'(d); wr_val = v;
    step();
  endtask

  task automatic wait_idle();
    int budget = 3000;
    while ((m_busy[0] | m_busy[1] | m_in_done[0] | m_in_done[1]) != 0 && budget > 0) begin
      step();
      budget--;
    end
    check("idle_budget", (budget > 0) ? 1 : 0, 1);
  endtask

  task automatic go(int l, logic lp);
    len = 10'(l); loop_en = lp; start = 1'b1; s0 = cyc;
    step();
  endtask

  task automatic load_s1();
    write_entry(0, 3, 3'b111); write_entry(1, 2, 3'b011); write_entry(2, 1, 3'b110);
  endtask

  initial begin
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();

    // One-shot, exact timing: applies in cycles 5,7,8 become visible one cycle later.
    load_s1();
    go(3, 1'b0);
    goto(7);  check("s1_r7_ch", o_ch[0], 3'b111);
    goto(8);  check("s1_r8_ch", o_ch[0], 3'b011); check("s1_r8_done", o_done[0], 0);
    goto(9);  check("s1_r9_ch", o_ch[0], 3'b110); check("s1_r9_done", o_done[0], 1);
              check("s1_r9_busy", o_busy[0], 0);  check("s1_r9_idx", o_idx[0], 2);
    goto(10); check("s1_r10_done", o_done[0], 0); check("s1_r10_ch", o_ch[0], 3'b110);
    wait_idle();

    // Prescaler 4 with a zero delta: applies in cycles 6 and 14.
    write_entry(0, 0, 3'b010); write_entry(1, 2, 3'b101);
    go(2, 1'b0);
    goto(6);  check("s2_r6_ch", o_ch[1], 3'b111);
    goto(7);  check("s2_r7_ch", o_ch[1], 3'b010);
    goto(14); check("s2_r14_ch", o_ch[1], 3'b010);
    goto(15); check("s2_r15_ch", o_ch[1], 3'b101); check("s2_r15_done", o_done[1], 1);
    wait_idle();

    // Loop: applies 4,6,8,10; loop_cnt steps on each wrap.
    write_entry(0, 2, 3'b001); write_entry(1, 2, 3'b100);
    go(2, 1'b1);
    goto(5);  check("s3_r5_ch", o_ch[0], 3'b001);
    goto(6);  check("s3_r6_lc", o_lc[0], 0);
    goto(7);  check("s3_r7_ch", o_ch[0], 3'b100); check("s3_r7_lc", o_lc[0], 1);
    goto(9);  check("s3_r9_ch", o_ch[0], 3'b001);
    goto(11); check("s3_r11_ch", o_ch[0], 3'b100); check("s3_r11_lc", o_lc[0], 2);
    abort = 1'b1; step();
    check("s3_abort_ch", o_ch[0], IDLE_V); check("s3_abort_busy", o_busy[0], 0);
    wait_idle();

    // Abort mid-WAIT, then replay from entry 0.
    load_s1();
    go(3, 1'b0);
    goto(6); abort = 1'b1; step();
    check("s4_r7_ch", o_ch[0], IDLE_V); check("s4_r7_busy", o_busy[0], 0);
    check("s4_r7_idx", o_idx[0], 0);
    step(); check("s4_r8_done", o_done[0], 0);
    wait_idle();
    go(3, 1'b0);
    goto(6); check("s4b_r6_ch", o_ch[0], 3'b111);
    goto(8); check("s4b_r8_ch", o_ch[0], 3'b011); check("s4b_r8_idx", o_idx[0], 1);
    wait_idle();

    // Guards: illegal lengths, start/write while busy.
    go(0, 1'b0);   check("g_len0_done", o_done[0], 1); check("g_len0_busy", o_busy[0], 0);
    step();        check("g_len0_done2", o_done[0], 0);
    go(513, 1'b0); check("g_len513_done", o_done[1], 1);
    step();
    go(3, 1'b0);
    goto(3); len = 10'd2; loop_en = 1'b1; start = 1'b1; step();
    goto(4); wr_en = 1'b1; wr_addr = 9'd1; wr_delta = 16'd5; wr_val = 3'b000; step();
    goto(8); check("g_rd_ch", o_ch[0], 3'b011);
    goto(9); check("g_rd_done", o_done[0], 1);
    wait_idle();

    // loop_cnt saturation with a one-entry, one-tick loop.
    write_entry(0, 0, 3'b101);
    go(1, 1'b1);
    goto(300);  check("sat_t1_lc", o_lc[0], 255);
    goto(1100); check("sat_t4_lc", o_lc[1], 255);
    abort = 1'b1; step();
    wait_idle();

    // Asynchronous reset mid-WAIT takes effect before the next edge.
    load_s1();
    go(3, 1'b0);
    goto(4);
    #2 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rst_t%0d_ch", j), o_ch[j], IDLE_V);
      check($sformatf("rst_t%0d_busy", j), o_busy[j], 0);
      check($sformatf("rst_t%0d_done", j), o_done[j], 0);
      check($sformatf("rst_t%0d_idx", j), o_idx[j], 0);
      check($sformatf("rst_t%0d_lc", j), o_lc[j], 0);
    end
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();

    // Randomised traffic over a 16-entry window.
    for (int i = 0; i < 16; i++) write_entry(i, $urandom_range(0, 4), 3'($urandom));
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        int r = $urandom_range(0, 19);
        start   = 1'b1;
        len     = (r < 16) ? 10'(r + 1) : (r < 18) ? 10'd0 : 10'd513;
        loop_en = ($urandom_range(0, 2) == 0);
      end
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) begin
        wr_en    = 1'b1;
        wr_addr  = 9'($urandom_range(0, 15));
        wr_delta = 16'($urandom_range(0, 4));
        wr_val   = 3'($urandom);
      end
      step();
    end
    abort = 1'b1; step();
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
